// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared constants for the fetch/data memory port arbiter.
// State codes, grant codes and default parameter values.
package mem_arb_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } gnt_e;

    localparam int STARVE_LIMIT_DEF   = 4;
    localparam int TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and data.
// Data wins unless fetch has already waited through STARVE_LIMIT data grants.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic       elig_i,
    input  logic       elig_d,
    input  logic [3:0] starve_cnt,
    output logic [1:0] gnt
);

    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    always_comb begin
        gnt = GNT_NONE;
        if (elig_d && (!elig_i || starve_cnt < SLIM)) begin
            gnt = GNT_D;
        end else if (elig_i) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the IF and MEM buses.
// One registered command at a time, with per-requester done/err/stall.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT   = STARVE_LIMIT_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIReq,
    input  logic [31:0] iIAddr,
    output logic [31:0] oIRData,
    output logic        oIDone,
    output logic        oIErr,
    output logic        oIStall,
    input  logic        iDReq,
    input  logic        iDWrite,
    input  logic [31:0] iDAddr,
    input  logic [31:0] iDWData,
    input  logic [3:0]  iDByteEnable,
    output logic [31:0] oDRData,
    output logic        oDDone,
    output logic        oDErr,
    output logic        oDStall,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemByteEnable,
    output logic        oMemRead,
    output logic        oMemWrite,
    input  logic [31:0] iMemRData,
    input  logic        iMemReady
);

    localparam logic [3:0] SLIM  = 4'(STARVE_LIMIT);
    localparam logic [7:0] TLAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] irdata_q, irdata_d;
    logic [31:0] drdata_q, drdata_d;
    logic        idone_q, idone_d;
    logic        ddone_q, ddone_d;
    logic        ierr_q, ierr_d;
    logic        derr_q, derr_d;

    logic        elig_i, elig_d;
    logic        timed_out, finish;
    logic [1:0]  pick, grant;

    // A requester's own done cycle must not re-trigger it.
    assign elig_i    = iIReq & ~idone_q;
    assign elig_d    = iDReq & ~ddone_q;
    assign timed_out = (tmo_q == TLAST) & ~iMemReady;
    assign finish    = (state_q != IDLE) & (iMemReady | timed_out);
    assign grant     = (state_q == IDLE) ? pick : GNT_NONE;

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .elig_i    (elig_i),
        .elig_d    (elig_d),
        .starve_cnt(starve_q),
        .gnt       (pick)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant == GNT_D) begin
                    state_d = BUSY_D;
                end else if (grant == GNT_I) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        idone_d  = 1'b0;
        ddone_d  = 1'b0;
        ierr_d   = 1'b0;
        derr_d   = 1'b0;
        tmo_d    = (state_q == IDLE) ? 8'd0 : tmo_q + 8'd1;

        unique case (grant)
            GNT_D: begin
                addr_d  = iDAddr;
                wdata_d = iDWData;
                be_d    = iDWrite ? iDByteEnable : 4'hF;
                rd_d    = ~iDWrite;
                wr_d    = iDWrite;
                tmo_d   = 8'd0;
            end
            GNT_I: begin
                addr_d  = iIAddr;
                wdata_d = 32'd0;
                be_d    = 4'hF;
                rd_d    = 1'b1;
                wr_d    = 1'b0;
                tmo_d   = 8'd0;
            end
            default: ;
        endcase

        if (finish) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
            if (state_q == BUSY_I) begin
                idone_d  = 1'b1;
                ierr_d   = ~iMemReady;
                irdata_d = iMemReady ? iMemRData : 32'd0;
            end else begin
                ddone_d  = 1'b1;
                derr_d   = ~iMemReady;
                drdata_d = (iMemReady & ~wr_q) ? iMemRData : 32'd0;
            end
        end
    end

    // Counts data wins over a waiting fetch; any gap in fetch demand resets it.
    always_comb begin
        starve_d = starve_q;
        if (!elig_i || grant == GNT_I) begin
            starve_d = 4'd0;
        end else if (grant == GNT_D && starve_q < SLIM) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            starve_q <= 4'd0;
            tmo_q    <= 8'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            be_q     <= 4'd0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            irdata_q <= 32'd0;
            drdata_q <= 32'd0;
            idone_q  <= 1'b0;
            ddone_q  <= 1'b0;
            ierr_q   <= 1'b0;
            derr_q   <= 1'b0;
        end else begin
            starve_q <= starve_d;
            tmo_q    <= tmo_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            idone_q  <= idone_d;
            ddone_q  <= ddone_d;
            ierr_q   <= ierr_d;
            derr_q   <= derr_d;
        end
    end

    assign oMemAddr       = addr_q;
    assign oMemWData      = wdata_q;
    assign oMemByteEnable = be_q;
    assign oMemRead       = rd_q;
    assign oMemWrite      = wr_q;
    assign oIRData        = irdata_q;
    assign oDRData        = drdata_q;
    assign oIDone         = idone_q;
    assign oDDone         = ddone_q;
    assign oIErr          = ierr_q;
    assign oDErr          = derr_q;
    assign oIStall        = iIReq & ~idone_q;
    assign oDStall        = iDReq & ~ddone_q;

endmodule
